// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-core definitions used by the ID-stage register file and the
// WB stage.
//   CPU_DATA_W / CPU_ADDR_W : default register data / address widths
//   REG_ZERO                : index of the hard-wired zero register
//   wr_port_t               : writeback port bundle {en, addr, data}
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic                  en;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy tracking for hazard stalls. An issue marks its destination
// busy; a writeback clears it. Issue beats writeback on the same register in
// the same cycle because the newer producer supersedes the older one.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   iss_en, iss_addr    : issue, mark iss_addr busy at next edge
//   wr0_en, wr0_addr    : writeback port 0, clear busy at next edge
//   wr1_en, wr1_addr    : writeback port 1, clear busy at next edge
//   busy_vec            : registered busy bits, one per register
//   any_busy            : OR of busy_vec
//   busy_cnt            : popcount of busy_vec
// ----------------------------------------------------------------------------
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_addr,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic                   any_busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
    // The zero register can never hold a pending producer.
    if (ZERO_REG && (gi == REG_ZERO)) begin : g_zero
      assign set_vec[gi] = 1'b0;
    end else begin : g_norm
      assign set_vec[gi] = iss_en && (iss_addr == ADDR_W'(gi));
    end
    assign clr_vec[gi] = (wr0_en && (wr0_addr == ADDR_W'(gi))) ||
                         (wr1_en && (wr1_addr == ADDR_W'(gi)));
  end

  always_comb begin
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + (ADDR_W+1)'(busy_q[i]);
    end
  end

  assign busy_vec = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// ID-stage register file: NUM_RD combinational read ports, two synchronous
// writeback ports (port 0 = ALU, port 1 = load; port 1 wins on collision),
// optional same-cycle write-to-read forwarding, optional hard-wired zero
// register, and a busy scoreboard for hazard stalls.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   rd_addr / rd_data / rd_busy : read port i in slice i of each bus
//   wr0_* / wr1_*               : writeback ports (en, addr, data)
//   iss_en, iss_addr            : issue, destination becomes busy
//   any_busy, busy_cnt          : summary of registered busy state
// ----------------------------------------------------------------------------
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     any_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  we0_vec;
  logic [DEPTH-1:0]  we1_vec;
  logic [DEPTH-1:0]  busy_vec;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    if (ZERO_REG && (gi == REG_ZERO)) begin : g_zero
      assign we0_vec[gi] = 1'b0;
      assign we1_vec[gi] = 1'b0;
    end else begin : g_norm
      assign we0_vec[gi] = wr0_en && (wr0_addr == ADDR_W'(gi));
      assign we1_vec[gi] = wr1_en && (wr1_addr == ADDR_W'(gi));
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we0_vec[i]) mem_d[i] = wr0_data;
      // Load writeback is applied last so it wins an address collision.
      if (we1_vec[i]) mem_d[i] = wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .busy_vec (busy_vec),
    .any_busy (any_busy),
    .busy_cnt (busy_cnt)
  );

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              wr0_hit;
    logic              wr1_hit;
    logic              iss_hit;
    logic [DATA_W-1:0] data_mux;
    logic              busy_mux;

    assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
    assign zero_hit = ZERO_REG && (addr == ADDR_W'(REG_ZERO));
    assign wr0_hit  = BYPASS && wr0_en && (wr0_addr == addr);
    assign wr1_hit  = BYPASS && wr1_en && (wr1_addr == addr);
    assign iss_hit  = iss_en && (iss_addr == addr);

    always_comb begin
      data_mux = mem_q[addr];
      busy_mux = busy_vec[addr];
      if (wr0_hit) data_mux = wr0_data;
      if (wr1_hit) data_mux = wr1_data;
      // A completing writeback releases the stall early unless a new
      // producer for the same register issues in this very cycle.
      if ((wr0_hit || wr1_hit) && !iss_hit) busy_mux = 1'b0;
      if (zero_hit) begin
        data_mux = '0;
        busy_mux = 1'b0;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_mux;
    assign rd_busy[gi]                  = busy_mux;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en;
  logic [4:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        any_busy;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_CNT  = 2;
  localparam int K_ANY  = 3;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .any_busy (any_busy),
    .busy_cnt (busy_cnt)
  );

  task automatic push(input string tag, input int kind, input int port, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Expect data and busy on both read ports.
  task automatic push_rd(input string tag, input logic [31:0] d0, input logic b0,
                         input logic [31:0] d1, input logic b1);
    push({tag, "_d0"}, K_DATA, 0, d0);
    push({tag, "_b0"}, K_BUSY, 0, {31'b0, b0});
    push({tag, "_d1"}, K_DATA, 1, d1);
    push({tag, "_b1"}, K_BUSY, 1, {31'b0, b1});
  endtask

  task automatic push_sum(input string tag, input int cnt, input logic any);
    push({tag, "_cnt"}, K_CNT, 0, 32'(cnt));
    push({tag, "_any"}, K_ANY, 0, {31'b0, any});
  endtask

  // Start a cycle just after the rising edge with all strobes idle.
  task automatic step_begin();
    @(posedge clk);
    #1;
    wr0_en = 1'b0;
    wr1_en = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  // Sample on the falling edge, pop every pending expectation and compare.
  task automatic check_now(input string tag);
    exp_t        e;
    logic [31:0] obs;
    int          n;
    @(negedge clk);
    n = exp_q.size();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA:  obs = rd_data[e.port*32 +: 32];
        K_BUSY:  obs = {31'b0, rd_busy[e.port]};
        K_CNT:   obs = 32'(busy_cnt);
        default: obs = {31'b0, any_busy};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
    $display("txn %s compared %0d", tag, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en = 1'b0; iss_addr = '0;

    step_begin();
    step_begin();
    rst = 1'b0;

    // Everything reads zero and idle after reset.
    for (int a = 0; a < 32; a++) begin
      if (a != 0) step_begin();
      set_rd(a, 31 - a);
      push_rd("rst_rd", 32'h0, 1'b0, 32'h0, 1'b0);
      push_sum("rst_sum", 0, 1'b0);
      check_now($sformatf("reset_read_%0d", a));
    end

    // Single write with same-cycle forwarding, then stored value.
    step_begin();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    set_rd(5, 6);
    push_rd("wr5_byp", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    check_now("wr0_addr5");
    step_begin();
    set_rd(5, 0);
    push_rd("wr5_st", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    check_now("read_addr5");

    // Writes to the zero register are dropped and never forwarded.
    step_begin();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
    set_rd(0, 0);
    push_rd("wr0_byp", 32'h0, 1'b0, 32'h0, 1'b0);
    check_now("wr0_addr0");
    step_begin();
    set_rd(0, 5);
    push_rd("wr0_st", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    check_now("read_addr0");

    // Both ports to one address: port 1 wins, forwarded and stored.
    step_begin();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    set_rd(7, 5);
    push_rd("coll_byp", 32'h22, 1'b0, 32'hDEADBEEF, 1'b0);
    check_now("dual_wr_addr7");
    step_begin();
    set_rd(7, 7);
    push_rd("coll_st", 32'h22, 1'b0, 32'h22, 1'b0);
    check_now("read_addr7");

    // Issue marks busy one cycle later.
    step_begin();
    iss_en = 1'b1; iss_addr = 5'd3;
    set_rd(3, 3);
    push_rd("iss3_same", 32'h0, 1'b0, 32'h0, 1'b0);
    push_sum("iss3_same", 0, 1'b0);
    check_now("iss_addr3");
    step_begin();
    set_rd(3, 4);
    push_rd("iss3_next", 32'h0, 1'b1, 32'h0, 1'b0);
    push_sum("iss3_next", 1, 1'b1);
    check_now("busy_addr3");

    // Load writeback releases busy and forwards data in the same cycle.
    step_begin();
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h55;
    set_rd(3, 3);
    push_rd("wb3_same", 32'h55, 1'b0, 32'h55, 1'b0);
    push_sum("wb3_same", 1, 1'b1);
    check_now("wr1_addr3");
    step_begin();
    push_rd("wb3_next", 32'h55, 1'b0, 32'h55, 1'b0);
    push_sum("wb3_next", 0, 1'b0);
    check_now("clear_addr3");

    // Issue and write to one address: data stored, busy stays set.
    step_begin();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hA5A5A5A5;
    set_rd(9, 9);
    push_rd("iw9_same", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);
    check_now("iss_wr_addr9");
    step_begin();
    iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(9, 0);
    push_rd("iw9_next", 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0);
    push_sum("iw9_next", 1, 1'b1);
    check_now("iss_addr0");
    step_begin();
    set_rd(0, 9);
    push_rd("iss0_next", 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
    push_sum("iss0_next", 1, 1'b1);
    check_now("after_iss0");

    // Fill regs 1..4 with data and busy.
    for (int r = 1; r <= 4; r++) begin
      step_begin();
      iss_en = 1'b1; iss_addr = 5'(r);
      wr1_en = 1'b1; wr1_addr = 5'(r); wr1_data = 32'h100 + 32'(r);
      check_now($sformatf("fill_%0d", r));
    end
    step_begin();
    set_rd(2, 4);
    push_rd("fill", 32'h102, 1'b1, 32'h104, 1'b1);
    push_sum("fill", 5, 1'b1);
    check_now("fill_check");

    // Reset with a concurrent write and issue: everything is lost.
    step_begin();
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hBAD0BAD0;
    iss_en = 1'b1; iss_addr = 5'd5;
    check_now("reset_mid");
    for (int a = 0; a < 32; a++) begin
      step_begin();
      rst = 1'b0;
      set_rd(a, 31 - a);
      push_rd("rst2_rd", 32'h0, 1'b0, 32'h0, 1'b0);
      push_sum("rst2_sum", 0, 1'b0);
      check_now($sformatf("post_reset_read_%0d", a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-port register file for the ID stage, replacing the fixed 32x32 two-read/one-write file. It has NUM_RD combinational read ports and two synchronous write ports (ALU writeback, load writeback). It also has optional write-to-read bypass, a hard-wired zero register, and a per-register busy scoreboard for hazard stalls. It sits between the decoder (read/issue) and the WB stage (writes).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to read outputs
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  clock
rst  in  1  reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  scoreboard busy flag for each read address
wr0_en  in  1  write port 0 enable (ALU WB)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load WB)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  ADDR_W  destination register of issuing instruction
any_busy  out  1  OR of all busy bits (registered state)
busy_cnt  out  ADDR_W+1  number of busy registers

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On a reset edge, every register and every busy bit clears to 0. Writes and issues presented in the reset cycle are discarded.
- After reset: rd_data=0 and rd_busy=0 for all ports; any_busy=0; busy_cnt=0.
- Storage is written on posedge clk; the new value is visible on the next cycle's read.
- Writes:
  - wrN_en writes wrN_data to wrN_addr.
  - Both ports enabled to the same address: port 1 wins.
  - Both ports enabled to different addresses: both are written.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads are combinational from rd_addr.
  - ZERO_REG=1 and addr=0: rd_data=0.
  - Otherwise, with BYPASS=1, if wr1_en and wr1_addr==addr, return wr1_data. Else if wr0_en and wr0_addr==addr, return wr0_data. Else return the stored value.
  - BYPASS=0: always the stored value.
- Scoreboard (busy[2**ADDR_W], registered):
  - iss_en sets busy[iss_addr] at the next edge.
  - wrN_en clears busy[wrN_addr] at the next edge.
  - Issue and write to the same address in the same cycle: set wins, because a new producer supersedes the old one.
  - ZERO_REG=1: busy[0] is never set.
  - Issue to an already-busy register: stays busy; no counting of multiple producers.
- rd_busy[i]:
  - Equals busy[rd_addr[i]].
  - With BYPASS=1, it is forced 0 when a same-cycle write targets that address and no same-cycle issue targets it.
  - Always 0 for addr 0 when ZERO_REG=1.
- any_busy and busy_cnt are computed from the registered busy vector, not bypassed. busy_cnt is the popcount and saturates naturally at 2**ADDR_W.
- Latency: read 0 cycles (combinational); write/busy update 1 cycle.
- Reset mid-operation: all state is lost; WB stage must not present writes for squashed instructions after reset.

Decomposition:
- Shared package cpu_pkg: DATA_W/ADDR_W defaults, REG_ZERO constant, and the write-port struct {en, addr, data}. Reuse the struct for WB stage ports.
- One sub-module, rf_scoreboard: busy vector, set/clear priority, popcount, any_busy.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_cnt=0.
- wr0 addr 5 data 0xDEADBEEF; next cycle read 5 -> 0xDEADBEEF.
  - Write addr 0 data 0x1234, then read 0 -> 0.
- Same-cycle wr0 addr 7 data 0x11 and wr1 addr 7 data 0x22, with read 7 in that cycle -> 0x22 (bypass). Next cycle stored value is 0x22.
  - BYPASS=0 build: the same-cycle read returns the old value.
- iss addr 3 -> next cycle rd_busy=1 for addr 3, busy_cnt=1, any_busy=1.
  - Then wr1 addr 3 data 0x55 -> same-cycle rd_busy=0 and rd_data=0x55.
  - Next cycle busy_cnt=0.
- Same cycle: iss addr 9 and wr0 addr 9 -> busy[9]=1 after the edge, data stored.
  - iss addr 0 -> busy_cnt unchanged.
- Busy on regs 1..4 with data written, then assert rst together with a write to addr 2 -> next cycle all reads 0, busy_cnt=0, the write is discarded.
